// File: rtl/text_pkg.sv
// Shared constants and types for the on-screen text writer: ASCII control
// codes, the writer state encoding and the default screen geometry.
package text_pkg;

  localparam int DEF_COLS = 20;
  localparam int DEF_ROWS = 7;
  localparam int CHAR_W   = 7;

  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_FF  = 8'h0C;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_SP  = 8'h20;
  localparam logic [7:0] ASCII_DEL = 8'h7F;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    CLEAR_ROW
  } state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= ASCII_SP) && (b < ASCII_DEL);
  endfunction

endpackage

// File: rtl/text_ram.sv
// Simple dual-port character RAM: one synchronous write port, one synchronous
// read port with old-data-on-collision behaviour.
module text_ram #(
  parameter int DEPTH = 140,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array and its read register have no reset so they map onto
  // block RAM; the writer's CLEAR_ALL sweep establishes the contents instead.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_buffer_writer.sv
// Terminal-style writer for the text screen: interprets an ASCII byte stream,
// maintains the cursor and keeps the character RAM read by the renderer.
module text_buffer_writer
  import text_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int CW   = $clog2(COLS),
  parameter int RW   = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic [CW-1:0]     rd_col,
  input  logic [RW-1:0]     rd_row,
  output logic [CHAR_W-1:0] rd_char,
  output logic [CW-1:0]     cursor_col,
  output logic [RW-1:0]     cursor_row,
  output logic              busy
);

  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = $clog2(DEPTH);

  state_t              state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;

  logic                we;
  logic [AW-1:0]       waddr;
  logic [CHAR_W-1:0]   wdata;

  logic [AW-1:0]       row_base;
  logic [AW-1:0]       cur_addr;
  logic [RW-1:0]       row_adv;
  logic                at_last_col;

  assign row_base    = AW'(row_q) * AW'(COLS);
  assign cur_addr    = row_base + AW'(col_q);
  assign row_adv     = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
  assign at_last_col = (col_q == CW'(COLS - 1));

  assign in_ready   = (state_q == IDLE);
  assign busy       = !in_ready;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    col_d   = col_q;
    row_d   = row_q;
    we      = 1'b0;
    waddr   = cur_addr;
    wdata   = '0;

    unique case (state_q)
      CLEAR_ALL: begin
        we    = 1'b1;
        waddr = ptr_q;
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end

      // The cursor row has already moved to the row being blanked.
      CLEAR_ROW: begin
        we    = 1'b1;
        waddr = row_base + ptr_q;
        if (ptr_q == AW'(COLS - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end

      IDLE: begin
        if (in_valid) begin
          if (is_printable(in_data)) begin
            we    = 1'b1;
            wdata = in_data[CHAR_W-1:0];
            if (at_last_col) begin
              col_d   = '0;
              row_d   = row_adv;
              state_d = CLEAR_ROW;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else if ((in_data == ASCII_LF) || (in_data == ASCII_CR)) begin
            col_d   = '0;
            row_d   = row_adv;
            state_d = CLEAR_ROW;
          end else if (in_data == ASCII_BS) begin
            // Stepping back from column 0 lands on the previous row's last
            // cell, which is linearly just cur_addr-1 in both cases.
            if (col_q != '0) begin
              col_d = col_q - 1'b1;
              we    = 1'b1;
              waddr = cur_addr - 1'b1;
            end else if (row_q != '0) begin
              row_d = row_q - 1'b1;
              col_d = CW'(COLS - 1);
              we    = 1'b1;
              waddr = cur_addr - 1'b1;
            end
          end else if (in_data == ASCII_FF) begin
            col_d   = '0;
            row_d   = '0;
            state_d = CLEAR_ALL;
          end
        end
      end

      default: state_d = CLEAR_ALL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR_ALL;
      ptr_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Read side: out-of-range coordinates are steered to cell 0 and masked.
  logic          rd_in_range;
  logic [AW-1:0] rd_addr;
  logic          rd_ok_q;
  logic [CHAR_W-1:0] ram_rdata;

  assign rd_in_range = ({1'b0, rd_col} < (CW + 1)'(COLS)) &&
                       ({1'b0, rd_row} < (RW + 1)'(ROWS));
  assign rd_addr     = rd_in_range ? AW'(rd_row) * AW'(COLS) + AW'(rd_col) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ok_q <= 1'b0;
    end else begin
      rd_ok_q <= rd_in_range;
    end
  end

  assign rd_char = rd_ok_q ? ram_rdata : '0;

  text_ram #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (CHAR_W)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(rd_addr),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_text_buffer_writer.sv
// Self-checking bench for text_buffer_writer: directed scenarios plus random
// byte/read traffic compared against a screen-level reference model.
module tb_text_buffer_writer;
  import text_pkg::*;

  localparam int COLS = 20;
  localparam int ROWS = 7;
  localparam int CW   = $clog2(COLS);
  localparam int RW   = $clog2(ROWS);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        in_data = 8'h00;
  logic [CW-1:0]     rd_col = '0;
  logic [RW-1:0]     rd_row = '0;
  logic [6:0]        rd_char;
  logic [CW-1:0]     cursor_col;
  logic [RW-1:0]     cursor_row;
  logic              busy;

  text_buffer_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rd_col    (rd_col),
    .rd_row    (rd_row),
    .rd_char   (rd_char),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: screen contents, cursor and remaining stall cycles.
  int scr [ROWS][COLS];
  int m_col, m_row, busy_left;
  bit pend_ok;
  int pend_val;

  function automatic void clear_screen();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 0;
  endfunction

  function automatic void new_line();
    m_col = 0;
    m_row = (m_row + 1) % ROWS;
    for (int c = 0; c < COLS; c++) scr[m_row][c] = 0;
    busy_left = COLS;
  endfunction

  function automatic void apply_byte(input int b);
    if (b >= 32 && b <= 126) begin
      scr[m_row][m_col] = b;
      if (m_col == COLS - 1) new_line();
      else m_col++;
    end else if (b == 10 || b == 13) begin
      new_line();
    end else if (b == 8) begin
      if (m_col > 0) begin
        m_col--;
        scr[m_row][m_col] = 0;
      end else if (m_row > 0) begin
        m_row--;
        m_col = COLS - 1;
        scr[m_row][m_col] = 0;
      end
    end else if (b == 12) begin
      clear_screen();
      m_col = 0;
      m_row = 0;
      busy_left = COLS * ROWS;
    end
  endfunction

  // One clock cycle, entered and left on a falling edge.
  task automatic step(input bit v, input logic [7:0] d, input int c, input int r);
    bit exp_ready;
    exp_ready = (busy_left == 0);
    check("in_ready", in_ready, exp_ready);
    check("busy", busy, !exp_ready);
    check("cursor_col", cursor_col, m_col);
    check("cursor_row", cursor_row, m_row);
    if (pend_ok) check("rd_char", rd_char, pend_val);
    in_valid = v;
    in_data  = d;
    rd_col   = CW'(c);
    rd_row   = RW'(r);
    if (c >= COLS || r >= ROWS) begin
      pend_ok  = 1'b1;
      pend_val = 0;
    end else if (exp_ready) begin
      pend_ok  = 1'b1;
      pend_val = scr[r][c];
    end else begin
      pend_ok = 1'b0;
    end
    @(posedge clk);
    if (v && exp_ready) apply_byte(int'(d));
    else if (busy_left > 0) busy_left--;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 0, 0);
    in_valid = 1'b0;
  endtask

  task automatic peek(input int r, input int c, output logic [6:0] v);
    step(1'b0, 8'h00, c, r);
    v = rd_char;
  endtask

  task automatic wait_ready(input string tag, input int exp_n);
    int n = 0;
    while (!in_ready && n < 300) begin
      step(in_valid, in_data, 0, 0);
      n++;
    end
    check(tag, n, exp_n);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_rd_char", rd_char, 0);
    check("rst_cursor_col", cursor_col, 0);
    check("rst_cursor_row", cursor_row, 0);
    clear_screen();
    m_col = 0;
    m_row = 0;
    busy_left = COLS * ROWS;
    pend_ok = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] v;
    int sel;

    @(negedge clk);

    // 1: reset with in_valid held high, then the whole screen reads blank
    in_valid = 1'b1;
    in_data  = 8'h41;
    do_reset();
    wait_ready("reset_busy_cycles", COLS * ROWS);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        peek(r, c, v);
        check("init_cell", v, 0);
      end

    // 2: "HI" back to back with no stall
    step(1'b1, 8'h48, 0, 0);
    step(1'b1, 8'h49, 0, 0);
    in_valid = 1'b0;
    check("hi_ready", in_ready, 1);
    check("hi_col", cursor_col, 2);
    check("hi_row", cursor_row, 0);
    peek(0, 0, v); check("hi_cell00", v, 7'h48);
    peek(0, 1, v); check("hi_cell01", v, 7'h49);

    // full-screen clear from idle
    send(ASCII_FF);
    wait_ready("ff_busy_cycles", COLS * ROWS);

    // 3: a full row of 'A' wraps to row 1 with a 20-cycle row clear
    for (int i = 0; i < COLS; i++) step(1'b1, 8'h41, 0, 0);
    in_valid = 1'b0;
    check("wrap_col", cursor_col, 0);
    check("wrap_row", cursor_row, 1);
    wait_ready("wrap_busy_cycles", COLS);
    for (int c = 0; c < COLS; c++) begin
      peek(0, c, v); check("row0_A", v, 7'h41);
      peek(1, c, v); check("row1_blank", v, 0);
    end

    // 4: backspace across the row boundary, then at the origin
    send(ASCII_BS);
    check("bs_wrap_col", cursor_col, COLS - 1);
    check("bs_wrap_row", cursor_row, 0);
    peek(0, COLS - 1, v); check("bs_cell", v, 0);
    peek(0, COLS - 2, v); check("bs_prev_cell", v, 7'h41);
    for (int i = 0; i < COLS - 1; i++) send(ASCII_BS);
    check("bs_origin_col", cursor_col, 0);
    send(ASCII_BS);
    check("bs_noop_col", cursor_col, 0);
    check("bs_noop_row", cursor_row, 0);
    check("bs_noop_ready", in_ready, 1);

    // 5: fill row 0, walk to row 6, newline wraps to a blanked row 0
    for (int i = 0; i < COLS; i++) step(1'b1, 8'(8'h61 + i), 0, 0);
    in_valid = 1'b0;
    wait_ready("fill_busy", COLS);
    peek(0, 5, v); check("fill_cell05", v, 7'h66);
    for (int i = 0; i < ROWS - 2; i++) begin
      send(ASCII_LF);
      wait_ready("lf_busy", COLS);
    end
    check("lf_row6", cursor_row, ROWS - 1);
    send(ASCII_LF);
    check("lf_wrap_col", cursor_col, 0);
    check("lf_wrap_row", cursor_row, 0);
    wait_ready("lf_wrap_busy", COLS);
    for (int c = 0; c < COLS; c++) begin
      peek(0, c, v); check("lf_wrap_blank", v, 0);
    end

    // 6: reset in the middle of a form-feed clear restarts the sweep
    send(ASCII_CR);
    wait_ready("cr_busy", COLS);
    send(8'h58);
    send(8'h59);
    send(ASCII_FF);
    for (int i = 0; i < 49; i++) step(1'b0, 8'h00, 0, 0);
    check("ff_mid_busy", busy, 1);
    do_reset();
    wait_ready("ff_reset_busy", COLS * ROWS);
    check("ff_reset_col", cursor_col, 0);
    check("ff_reset_row", cursor_row, 0);
    send(8'h07);
    check("bel_col", cursor_col, 0);
    check("bel_row", cursor_row, 0);
    check("bel_ready", in_ready, 1);
    peek(0, 0, v); check("bel_cell", v, 0);

    // random traffic against the model, including out-of-range reads
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] b;
      sel = $urandom_range(0, 99);
      if (sel < 70)      b = 8'($urandom_range(32, 126));
      else if (sel < 78) b = ($urandom_range(0, 1) != 0) ? ASCII_LF : ASCII_CR;
      else if (sel < 90) b = ASCII_BS;
      else if (sel < 92) b = ASCII_FF;
      else               b = 8'($urandom_range(0, 255));
      step($urandom_range(0, 3) != 0, b, $urandom_range(0, COLS + 3), $urandom_range(0, ROWS));
    end
    step(1'b0, 8'h00, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
